// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the ROM cs/ready handshake and
// buffers fetched words with their PC in a small prefetch FIFO for decode.
module instr_fetch_unit #(
  parameter int unsigned             ADDR_W   = 16,
  parameter int unsigned             DATA_W   = 16,
  parameter logic [ADDR_W-1:0]       PC_RESET = '0,
  parameter int unsigned             DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_LO = 2'd2,
    WAIT_HI = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               discard_q, discard_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
  logic [DATA_W-1:0]  fifo_instr [DEPTH];
  logic [ADDR_W-1:0]  head_pc_d;
  logic [DATA_W-1:0]  head_instr_d;
  logic               capture;
  logic               push;
  logic               pop;
  logic               issue;

  // Next-state, PC, discard and FIFO bookkeeping
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    head_pc_d    = out_pc;
    head_instr_d = out_instr;

    // In IDLE nothing is in flight, so the occupancy check reduces to count
    issue   = (state_q == IDLE) && fetch_en && !redirect_valid &&
              (count_q < CNT_W'(DEPTH));
    capture = (state_q == WAIT_HI) && mem_ready;
    push    = capture && !discard_q && !redirect_valid;
    pop     = out_valid && out_ready && !redirect_valid;

    unique case (state_q)
      IDLE:    if (issue) state_d = REQ;
      REQ:     state_d = WAIT_LO;
      WAIT_LO: if (!mem_ready) state_d = WAIT_HI;
      WAIT_HI: if (mem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A redirect wins over an increment, including on the capture cycle
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + ADDR_W'(1);

    // Only a transaction that is still running after this edge is tainted
    if (capture)                              discard_d = 1'b0;
    else if (redirect_valid && state_q != IDLE) discard_d = 1'b1;

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    // Head tracks the entry at the next read pointer; holds when empty
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_pc_d    = pc_q;
        head_instr_d = mem_data;
      end else begin
        head_pc_d    = fifo_pc[rd_ptr_d];
        head_instr_d = fifo_instr[rd_ptr_d];
      end
    end
  end

  // State, PC and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      discard_q   <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      mem_cs      <= 1'b0;
      mem_address <= PC_RESET;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_cs      <= (state_d == REQ);
      if (issue) mem_address <= pc_q;
      out_valid   <= (count_d != '0);
      out_instr   <= head_instr_d;
      out_pc      <= head_pc_d;
      busy        <= (state_d != IDLE);
    end
  end

  // Prefetch FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr_q]    <= pc_q;
      fifo_instr[wr_ptr_q] <= mem_data;
    end
  end

endmodule
